// File: rtl/clken_gen_multi.sv
// Multi-channel frame-locked clock-enable generator: evenly spreads T_c strobes
// per FRAME master-clock cycles on each channel, with pause, resync and ce_d.
module clken_gen_multi #(
  parameter int CHANNELS = 2,
  parameter int FRAME    = 25,
  parameter int CNT_W    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pause,
  input  logic                      resync,
  input  logic [CHANNELS*CNT_W-1:0] ticks,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       ce_d,
  output logic                      frame_start,
  output logic [CNT_W-1:0]          phase
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME - 1);
  localparam logic [CNT_W:0]   FRAME_V = (CNT_W + 1)'(FRAME);

  // Tick counts above FRAME saturate to one strobe per cycle.
  function automatic logic [CNT_W:0] sat_ticks(input logic [CNT_W-1:0] t);
    logic [CNT_W:0] tw;
    tw = {1'b0, t};
    return (tw > FRAME_V) ? FRAME_V : tw;
  endfunction

  function automatic logic [CNT_W:0] wrap_acc(input logic [CNT_W:0] a,
                                             input logic [CNT_W:0] t);
    logic [CNT_W+1:0] s;
    s = {1'b0, a} + {1'b0, t};
    if (s >= {1'b0, FRAME_V}) s = s - {1'b0, FRAME_V};
    return s[CNT_W:0];
  endfunction

  logic [CNT_W:0]      tick_sh [CHANNELS];
  logic [CNT_W:0]      acc     [CHANNELS];
  logic [CHANNELS-1:0] fire_p0;
  logic                boundary;

  always_comb begin
    boundary = resync || (phase == LAST);
    fire_p0  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fire_p0[c] = (acc[c] < tick_sh[c]);
    end
  end

  // p0 -> p1: strobe decisions are registered onto ce/frame_start, then ce_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= '0;
      ce          <= '0;
      ce_d        <= '0;
      frame_start <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]     <= '0;
        tick_sh[c] <= sat_ticks(ticks[c*CNT_W +: CNT_W]);
      end
    end else begin
      ce_d <= ce;
      if (pause) begin
        ce          <= '0;
        frame_start <= 1'b0;
      end else begin
        ce          <= fire_p0;
        frame_start <= (phase == '0);
        if (boundary) begin
          phase <= '0;
          for (int c = 0; c < CHANNELS; c++) begin
            acc[c]     <= '0;
            tick_sh[c] <= sat_ticks(ticks[c*CNT_W +: CNT_W]);
          end
        end else begin
          phase <= phase + CNT_W'(1);
          for (int c = 0; c < CHANNELS; c++) begin
            acc[c] <= wrap_acc(acc[c], tick_sh[c]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clken_gen_multi.sv
// Bench for clken_gen_multi: directed scenarios plus random traffic, checked
// against a model that fires channel c at phase p iff (p*T) mod FRAME < T.
module tb_clken_gen_multi;
  localparam int CHANNELS = 2;
  localparam int FRAME    = 25;
  localparam int CNT_W    = 5;

  logic                      clk = 1'b0;
  logic                      reset, pause, resync;
  logic [CHANNELS*CNT_W-1:0] ticks;
  logic [CHANNELS-1:0]       ce, ce_d;
  logic                      frame_start;
  logic [CNT_W-1:0]          phase;

  clken_gen_multi #(.CHANNELS(CHANNELS), .FRAME(FRAME), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pause(pause), .resync(resync), .ticks(ticks),
    .ce(ce), .ce_d(ce_d), .frame_start(frame_start), .phase(phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  int                  mphase;
  int                  mt [CHANNELS];
  logic [CHANNELS-1:0] ece, eced;
  logic                efs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampt(input int t);
    return (t > FRAME) ? FRAME : t;
  endfunction

  task automatic reload();
    for (int c = 0; c < CHANNELS; c++) mt[c] = clampt(int'(ticks[c*CNT_W +: CNT_W]));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      ece = '0; eced = '0; efs = 1'b0; mphase = 0;
      reload();
    end else begin
      eced = ece;
      if (pause) begin
        ece = '0; efs = 1'b0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) ece[c] = (((mphase * mt[c]) % FRAME) < mt[c]);
        efs = (mphase == 0);
        if (resync || mphase == FRAME - 1) begin
          mphase = 0;
          reload();
        end else begin
          mphase++;
        end
      end
    end
    #1;
    chk("phase", 32'(phase), 32'(mphase));
    chk("ce", 32'(ce), 32'(ece));
    chk("ce_d", 32'(ce_d), 32'(eced));
    chk("frame_start", 32'(frame_start), 32'(efs));
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 2 * FRAME && mphase != p; i++) step();
    chk("reach_phase", 32'(mphase), 32'(p));
  endtask

  // Count strobes over one full frame window of unpaused cycles.
  task automatic count_frame(input int exp0, input int exp1, input int expfs);
    int n0, n1, nf;
    n0 = 0; n1 = 0; nf = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n0 += int'(ce[0]); n1 += int'(ce[1]); nf += int'(frame_start);
    end
    chk("count_ch0", 32'(n0), 32'(exp0));
    chk("count_ch1", 32'(n1), 32'(exp1));
    chk("count_fs", 32'(nf), 32'(expfs));
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; resync = 1'b0;
    ticks = {5'd6, 5'd8};
    repeat (3) step();
    reset = 1'b0;

    // Nominal 8/6 pattern over three frames
    for (int f = 0; f < 3; f++) count_frame(8, 6, 1);

    // Mid-frame tick change only takes effect at the next frame
    run_to(12);
    ticks = {5'd6, 5'd5};
    repeat (FRAME) step();
    count_frame(5, 6, 1);

    // Zero ticks and over-range ticks
    ticks = {5'd31, 5'd0};
    run_to(0);
    run_to(FRAME - 1);
    count_frame(0, 25, 1);

    // Pause for 7 cycles at phase 9
    ticks = {5'd6, 5'd8};
    run_to(0); run_to(FRAME - 1); run_to(9);
    pause = 1'b1;
    repeat (7) step();
    pause = 1'b0;
    run_to(FRAME - 1);

    // Resync at phase 17
    run_to(17);
    resync = 1'b1;
    step();
    resync = 1'b0;
    repeat (5) step();

    // Reset mid-frame for 2 cycles
    run_to(11);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();
    count_frame(8, 6, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 99) < 2);
      pause  = ($urandom_range(0, 99) < 10);
      resync = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 8) ticks = CHANNELS*CNT_W'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
